// File: rtl/lane_stripe_arbiter.sv
// rtl/lane_stripe_arbiter.sv - TLP/DLLP arbiter that frames packets (STP/SDP..END) and pads to lane 0.
// Build option: LANE_ARB_DLLP_PRIORITY_EN makes DLLP win every IDLE tie instead of round-robin.
module lane_stripe_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] tlp_data_i,
  input  logic                  tlp_valid_i,
  input  logic                  tlp_last_i,
  output logic                  tlp_ready_o,
  input  logic [DATA_WIDTH-1:0] dllp_data_i,
  input  logic                  dllp_valid_i,
  input  logic                  dllp_last_i,
  output logic                  dllp_ready_o,
  input  logic [NUM_LANES-1:0]  num_lanes_enabled_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_k_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            grant_o,
  output logic                  busy_o
);
  localparam int PW = $clog2(NUM_LANES) + 1;
  localparam logic [DATA_WIDTH-1:0] SYM_STP = DATA_WIDTH'(8'hFB);
  localparam logic [DATA_WIDTH-1:0] SYM_SDP = DATA_WIDTH'(8'h5C);
  localparam logic [DATA_WIDTH-1:0] SYM_END = DATA_WIDTH'(8'hFD);
  localparam logic [DATA_WIDTH-1:0] SYM_PAD = DATA_WIDTH'(8'hF7);

  typedef enum logic [2:0] {S_IDLE, S_START, S_PAYLOAD, S_END, S_PAD} state_t;

  state_t        state_r, state_nxt;
  logic [PW-1:0] lanes_r, lanes_nxt, pos_r, pos_wrap, lane_cnt;
  logic [1:0]    grant_r, grant_nxt;
  logic          pick_dllp, done, src_valid, src_last, xfer;

  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) lane_cnt = lane_cnt + PW'(num_lanes_enabled_i[i]);
  end

  assign pos_wrap = (pos_r == lanes_r - PW'(1)) ? '0 : pos_r + PW'(1);
  assign xfer     = out_valid_o & out_ready_i;

`ifdef LANE_ARB_DLLP_PRIORITY_EN
  assign pick_dllp = dllp_valid_i;
`else
  logic last_dllp_r;  // 1 when the most recent completed packet was a DLLP

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   last_dllp_r <= 1'b1;
    else if (done) last_dllp_r <= grant_r[1];
  end

  assign pick_dllp = dllp_valid_i & (~tlp_valid_i | ~last_dllp_r);
`endif

  always_comb begin
    state_nxt    = state_r;
    lanes_nxt    = lanes_r;
    grant_nxt    = grant_r;
    done         = 1'b0;
    src_valid    = 1'b0;
    src_last     = 1'b0;
    out_data_o   = '0;
    out_k_o      = 1'b0;
    out_valid_o  = 1'b0;
    tlp_ready_o  = 1'b0;
    dllp_ready_o = 1'b0;
    case (state_r)
      S_IDLE: begin
        if ((tlp_valid_i | dllp_valid_i) && lane_cnt != '0) begin
          lanes_nxt = lane_cnt;
          grant_nxt = pick_dllp ? 2'b10 : 2'b01;
          state_nxt = S_START;
        end
      end
      S_START: begin
        out_valid_o = 1'b1;
        out_k_o     = 1'b1;
        out_data_o  = grant_r[1] ? SYM_SDP : SYM_STP;
        if (out_ready_i) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (grant_r[1]) begin
          out_data_o   = dllp_data_i;
          src_valid    = dllp_valid_i;
          src_last     = dllp_last_i;
          dllp_ready_o = out_ready_i;
        end else begin
          out_data_o  = tlp_data_i;
          src_valid   = tlp_valid_i;
          src_last    = tlp_last_i;
          tlp_ready_o = out_ready_i;
        end
        out_valid_o = src_valid;
        if (src_valid && out_ready_i && src_last) state_nxt = S_END;
      end
      S_END: begin
        out_valid_o = 1'b1;
        out_k_o     = 1'b1;
        out_data_o  = SYM_END;
        if (out_ready_i) begin
          if (pos_wrap != '0) begin
            state_nxt = S_PAD;
          end else begin
            state_nxt = S_IDLE;
            done      = 1'b1;
          end
        end
      end
      S_PAD: begin
        out_valid_o = 1'b1;
        out_k_o     = 1'b1;
        out_data_o  = SYM_PAD;
        if (out_ready_i && pos_wrap == '0) begin
          state_nxt = S_IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (done) grant_nxt = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_IDLE;
      lanes_r <= '0;
      pos_r   <= '0;
      grant_r <= '0;
    end else begin
      state_r <= state_nxt;
      lanes_r <= lanes_nxt;
      grant_r <= grant_nxt;
      if (xfer) pos_r <= pos_wrap;
    end
  end

  assign grant_o = grant_r;
  assign busy_o  = (state_r != S_IDLE);
endmodule

// File: tb/tb_lane_stripe_arbiter.sv
// tb/tb_lane_stripe_arbiter.sv - scoreboard bench for lane_stripe_arbiter with randomized traffic.
module tb_lane_stripe_arbiter;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    tlp_data = '0, dllp_data = '0;
  logic          tlp_valid = 1'b0, tlp_last = 1'b0, dllp_valid = 1'b0, dllp_last = 1'b0;
  logic          tlp_ready, dllp_ready;
  logic [NL-1:0] lanes_en = '1;
  logic [7:0]    out_data;
  logic          out_k, out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    grant;
  logic          busy;

  lane_stripe_arbiter #(.NUM_LANES(NL), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tlp_data_i(tlp_data), .tlp_valid_i(tlp_valid), .tlp_last_i(tlp_last), .tlp_ready_o(tlp_ready),
    .dllp_data_i(dllp_data), .dllp_valid_i(dllp_valid), .dllp_last_i(dllp_last), .dllp_ready_o(dllp_ready),
    .num_lanes_enabled_i(lanes_en),
    .out_data_o(out_data), .out_k_o(out_k), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic k; logic [1:0] grant; logic eop; } exp_t;
  typedef struct { logic [7:0] data; logic last; } src_t;

  exp_t sb[$];
  src_t tlp_q[$], dllp_q[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0, popped = 0;
  bit   idle_chk = 0, abort = 0, run = 0, gaps = 0;
  int   ready_mode = 0;
  bit   model_last_dllp = 1;

  // Monitor: every output transfer must match the head of the expected stream.
  always @(negedge clk) begin
    if (!rst_n) begin
      idle_chk = 0;
    end else begin
      if (idle_chk) begin
        vectors++;
        if (busy !== 1'b0 || grant !== 2'b00) begin
          miscompares++;
          $display("FAIL idle_after_pkt: busy=%0b grant=%b, required busy=0 grant=00", busy, grant);
        end
        idle_chk = 0;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_byte: data=%h k=%0b, required no transfer", out_data, out_k);
        end else begin
          mon_e = sb.pop_front();
          popped++;
          if ({out_data, out_k, grant} !== {mon_e.data, mon_e.k, mon_e.grant}) begin
            miscompares++;
            $display("FAIL out_byte: data=%h k=%0b grant=%b, required data=%h k=%0b grant=%b",
                     out_data, out_k, grant, mon_e.data, mon_e.k, mon_e.grant);
          end
          idle_chk = mon_e.eop;
        end
      end
    end
  end

  task automatic push_pkt(input bit is_dllp, input int len, input int base, input int lanes);
    exp_t e;
    src_t s;
    int   pad;
    e.grant = is_dllp ? 2'b10 : 2'b01;
    e.data = is_dllp ? 8'h5C : 8'hFB; e.k = 1; e.eop = 0;
    sb.push_back(e);
    for (int i = 0; i < len; i++) begin
      s.data = (base >= 0) ? 8'(base + i) : 8'($urandom);
      s.last = (i == len - 1);
      if (is_dllp) dllp_q.push_back(s); else tlp_q.push_back(s);
      e.data = s.data; e.k = 0; e.eop = 0;
      sb.push_back(e);
    end
    pad = (lanes - ((len + 2) % lanes)) % lanes;
    e.data = 8'hFD; e.k = 1; e.eop = (pad == 0);
    sb.push_back(e);
    for (int p = 0; p < pad; p++) begin
      e.data = 8'hF7; e.k = 1; e.eop = (p == pad - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive_src(input bit d);
    bit acc;
    bit first = 1;
    while ((d ? dllp_q.size() : tlp_q.size()) > 0 && !abort) begin
      if (d) begin
        dllp_valid = first || !gaps || ($urandom_range(0, 3) != 0);
        dllp_data = dllp_q[0].data; dllp_last = dllp_q[0].last;
      end else begin
        tlp_valid = first || !gaps || ($urandom_range(0, 3) != 0);
        tlp_data = tlp_q[0].data; tlp_last = tlp_q[0].last;
      end
      @(negedge clk);
      acc = d ? (dllp_valid && dllp_ready) : (tlp_valid && tlp_ready);
      @(posedge clk); #1;
      if (acc) begin
        if (d) void'(dllp_q.pop_front()); else void'(tlp_q.pop_front());
        first = 0;
      end
    end
    if (d) begin dllp_valid = 0; dllp_last = 0; end
    else begin tlp_valid = 0; tlp_last = 0; end
  endtask

  task automatic drive_ready();
    int n = 0;
    while (run) begin
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (n % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      n++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic scenario(input int tlen, input int dlen, input int tbase,
                          input logic [NL-1:0] en_a, input logic [NL-1:0] en_b,
                          input int rmode, input bit gap, input int rst_after);
    bit first_dllp;
    int cyc, start_pops;
    if (tlen > 0 && dlen > 0) begin
`ifdef LANE_ARB_DLLP_PRIORITY_EN
      first_dllp = 1;
`else
      first_dllp = !model_last_dllp;
`endif
    end else begin
      first_dllp = (dlen > 0);
    end
    if (first_dllp) push_pkt(1, dlen, -1, $countones(en_a));
    else            push_pkt(0, tlen, tbase, $countones(en_a));
    if (tlen > 0 && dlen > 0) begin
      if (first_dllp) push_pkt(0, tlen, tbase, $countones(en_b));
      else            push_pkt(1, dlen, -1, $countones(en_b));
      model_last_dllp = !first_dllp;
    end else begin
      model_last_dllp = first_dllp;
    end
    lanes_en = en_a; ready_mode = rmode; gaps = gap; abort = 0; run = 1;
    start_pops = popped;
    @(posedge clk); #1;
    fork
      drive_src(0);
      drive_src(1);
      drive_ready();
      begin
        if (en_b != en_a) begin
          cyc = 0;
          while (grant == 2'b00 && !abort && cyc < 100) begin @(posedge clk); #1; cyc++; end
          repeat (2) @(posedge clk);
          #1 lanes_en = en_b;
        end
      end
      begin
        cyc = 0;
        if (rst_after >= 0) begin
          while (popped < start_pops + 1 + rst_after && cyc < 500) begin @(negedge clk); #1; cyc++; end
          #1 rst_n = 0;
          #1;
          vectors++;
          if (cyc >= 500 || {out_valid, out_k, out_data, grant, busy, tlp_ready, dllp_ready} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_mid_packet: valid=%0b k=%0b data=%h grant=%b busy=%0b waited=%0d, required all 0",
                     out_valid, out_k, out_data, grant, busy, cyc);
          end
        end else begin
          while (!(sb.size() == 0 && busy == 1'b0 && tlp_q.size() == 0 && dllp_q.size() == 0) && cyc < 3000) begin
            @(negedge clk); #1; cyc++;
          end
          vectors++;
          if (cyc >= 3000) begin
            miscompares++;
            $display("FAIL scenario_done: %0d bytes still expected, required 0", sb.size());
          end
        end
        run = 0; abort = 1;
      end
    join
    if (rst_after >= 0) begin
      sb.delete(); tlp_q.delete(); dllp_q.delete();
      model_last_dllp = 1;
      repeat (2) @(negedge clk);
      rst_n = 1;
    end
  endtask

  initial begin
    logic [NL-1:0] en_opts [3];
    logic [NL-1:0] en;
    int tl, dl;
    en_opts[0] = 4'b0001; en_opts[1] = 4'b0011; en_opts[2] = 4'b1111;
    #3;
    vectors++;
    if ({out_valid, out_k, out_data, grant, busy, tlp_ready, dllp_ready} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0b k=%0b data=%h grant=%b busy=%0b, required all 0",
               out_valid, out_k, out_data, grant, busy);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    lanes_en = '0;
    @(posedge clk); #1 tlp_valid = 1; tlp_data = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || grant !== 2'b00 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_lanes_idle: busy=%0b grant=%b valid=%0b, required 0 00 0", busy, grant, out_valid);
      end
    end
    tlp_valid = 0;

    scenario(3, 4, -1, 4'b1111, 4'b1111, 0, 0, -1);   // simultaneous requests after reset
    scenario(5, 0, 1, 4'b1111, 4'b1111, 0, 0, -1);    // 01..05 on x4
    scenario(0, 6, -1, 4'b0001, 4'b0001, 0, 0, -1);   // x1 never pads
    scenario(5, 0, 1, 4'b1111, 4'b1111, 1, 1, -1);    // ready toggling, source gaps
    scenario(6, 4, -1, 4'b1111, 4'b0011, 2, 1, -1);   // lane width change mid-packet
    scenario(8, 0, 1, 4'b1111, 4'b1111, 0, 0, 3);     // reset after 3 payload bytes
    scenario(4, 0, -1, 4'b1111, 4'b1111, 0, 0, -1);   // first packet after reset
    for (int r = 0; r < 30; r++) begin
      tl = $urandom_range(0, 8);
      dl = $urandom_range(0, 8);
      if (tl == 0 && dl == 0) tl = 1;
      en = en_opts[$urandom_range(0, 2)];
      scenario(tl, dl, -1, en, en, 2, 1, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
